// File: rtl/digi_tube_sched.sv
// Round-robin display scheduler: shares one 4-digit seven-segment tube between
// three BCD requesters with a minimum dwell per grant and registered digit outputs.
module digi_tube_sched #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int HOLD_MS  = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [15:0] data_0,
  input  logic [15:0] data_1,
  input  logic [15:0] data_2,
  output logic [2:0]  grant,
  output logic [3:0]  d_0,
  output logic [3:0]  d_1,
  output logic [3:0]  d_2,
  output logic [3:0]  d_3,
  output logic        blank,
  output logic        switch_p
);

  localparam int HOLD_RAW = CLK_FREQ / 1000 * HOLD_MS;
  localparam int HOLD_CYC = (HOLD_RAW < 1) ? 1 : HOLD_RAW;
  localparam int DW       = $clog2(HOLD_CYC) + 1;
  localparam logic [DW-1:0] DWELL_MAX = DW'(HOLD_CYC - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SHOW = 1'b1;

  logic [0:0]    state, state_nx;
  logic [1:0]    last, last_nx;
  logic [DW-1:0] dwell, dwell_nx;
  logic [2:0]    grant_nx;

  logic [3:0]    cand;
  logic [1:0]    rr_1, rr_2, pick_idx;
  logic          pick_ok;
  logic          held;
  logic [15:0]   shown;

  function automatic logic [1:0] rr_succ(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // While showing, the current grantee is masked out so an expiring grant
  // always moves on; the padded bit keeps index 3 from ever being selected.
  always_comb begin
    cand     = {1'b0, (state == ST_IDLE) ? req : (req & ~grant)};
    rr_1     = rr_succ(last);
    rr_2     = rr_succ(rr_1);
    pick_ok  = |cand;
    pick_idx = last;
    if (cand[rr_2]) pick_idx = rr_2;
    if (cand[rr_1]) pick_idx = rr_1;
  end

  assign held = |(req & grant);

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    last_nx  = last;
    dwell_nx = dwell;
    case (state)
      ST_IDLE: begin
        if (pick_ok) begin
          grant_nx = 3'(3'b001 << pick_idx);
          last_nx  = pick_idx;
          dwell_nx = '0;
          state_nx = ST_SHOW;
        end
      end
      default: begin
        if (!held) begin
          dwell_nx = '0;
          if (pick_ok) begin
            grant_nx = 3'(3'b001 << pick_idx);
            last_nx  = pick_idx;
          end else begin
            grant_nx = 3'b000;
            state_nx = ST_IDLE;
          end
        end else if (dwell != DWELL_MAX) begin
          dwell_nx = dwell + DW'(1);
        end else begin
          // Expiry with no competitor re-grants in place, which is not a switch.
          dwell_nx = '0;
          if (pick_ok) begin
            grant_nx = 3'(3'b001 << pick_idx);
            last_nx  = pick_idx;
          end
        end
      end
    endcase
  end

  always_comb begin
    case (grant)
      3'b001:  shown = data_0;
      3'b010:  shown = data_1;
      3'b100:  shown = data_2;
      default: shown = 16'hFFFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      grant    <= 3'b000;
      last     <= 2'd2;
      dwell    <= '0;
      switch_p <= 1'b0;
    end else begin
      state    <= state_nx;
      grant    <= grant_nx;
      last     <= last_nx;
      dwell    <= dwell_nx;
      switch_p <= (grant_nx != grant);
    end
  end

  // Digits follow the grant register one edge later, using live source data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_0   <= 4'hF;
      d_1   <= 4'hF;
      d_2   <= 4'hF;
      d_3   <= 4'hF;
      blank <= 1'b1;
    end else begin
      d_0   <= shown[3:0];
      d_1   <= shown[7:4];
      d_2   <= shown[11:8];
      d_3   <= shown[15:12];
      blank <= (grant == 3'b000);
    end
  end

endmodule
